// File: rtl/aes_arb_pkg.sv
// Shared definitions for the AES core arbiter slice.
//   - arb_state_e     : arbiter FSM state encoding
//   - AES_BLOCK_W     : AES block width (plaintext / ciphertext)
//   - AES_KEY_W       : AES-256 key width
//   - DEFAULT_TIMEOUT : default watchdog limit in cycles from core start
package aes_arb_pkg;

    localparam int AES_BLOCK_W     = 128;
    localparam int AES_KEY_W       = 256;
    localparam int DEFAULT_TIMEOUT = 96;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin picker.
// Ports:
//   req         in  NREQ   request vector
//   last_grant  in  IDX_W  index granted most recently
//   grant       out NREQ   one-hot grant (all zero when no request)
//   grant_idx   out IDX_W  index of the granted requester
//   grant_valid out 1      at least one request present
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    // Search starts one past the previous winner and wraps, so the
    // previous winner is considered last.
    always_comb begin
        int idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one external AES-256 core between NREQ requesters, one job at a time.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        per-requester request handshake
//   req_data/req_key           per-requester plaintext / key, slice i = requester i
//   rsp_valid/rsp_ready        per-requester response handshake
//   rsp_data, rsp_err          shared ciphertext and timeout flag
//   core_start                 one-cycle start to the core
//   core_data_in, core_key     plaintext / key presented to the core
//   core_data_out, core_valid  core result and completion pulse
//   busy                       high whenever a job is outstanding
module aes_core_arbiter
    import aes_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*AES_BLOCK_W-1:0] req_data,
    input  logic [NREQ*AES_KEY_W-1:0]   req_key,
    output logic [NREQ-1:0]             rsp_valid,
    input  logic [NREQ-1:0]             rsp_ready,
    output logic [AES_BLOCK_W-1:0]      rsp_data,
    output logic                        rsp_err,
    output logic                        core_start,
    output logic [AES_BLOCK_W-1:0]      core_data_in,
    output logic [AES_KEY_W-1:0]        core_key,
    input  logic [AES_BLOCK_W-1:0]      core_data_out,
    input  logic                        core_valid,
    output logic                        busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // The counter is 0 in the first BUSY cycle; the watchdog fires in the
    // cycle whose increment would bring it to TIMEOUT-1, so the error
    // response is visible exactly TIMEOUT cycles after the core_start cycle.
    // TIMEOUT must be at least 2.
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT - 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);

    arb_state_e                state, state_next;
    logic [IDX_W-1:0]          last_grant;
    logic [NREQ-1:0]           grant;
    logic [IDX_W-1:0]          grant_idx;
    logic                      grant_valid;
    logic [CNT_W-1:0]          timeout_cnt;
    logic                      timeout_hit;
    logic                      rsp_take;
    logic [AES_BLOCK_W-1:0]    hold_data;
    logic [AES_KEY_W-1:0]      hold_key;
    logic [IDX_W-1:0]          hold_id;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req         (req_valid),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign timeout_hit = (timeout_cnt == CNT_FIRE);
    assign rsp_take    = rsp_ready[hold_id];

    // rst_n gates req_ready so it drops immediately while reset is held,
    // even though IDLE would otherwise present the grant.
    assign req_ready    = (rst_n && state == IDLE) ? grant : '0;
    assign core_start   = (state == START);
    assign busy         = (state != IDLE);
    assign core_data_in = hold_data;
    assign core_key     = hold_key;

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) begin
            rsp_valid[hold_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // In IDLE a present grant is always a completed handshake, since
    // req_ready mirrors the grant.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = START;
            START:   state_next = BUSY;
            BUSY:    if (core_valid || timeout_hit) state_next = RESP;
            RESP:    if (rsp_take) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // core_valid is only looked at in BUSY, so stray pulses elsewhere are
    // dropped; a completion in the watchdog cycle takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            last_grant  <= IDX_W'(NREQ - 1);
        end else begin
            case (state)
                START: timeout_cnt <= '0;
                BUSY: begin
                    if (timeout_cnt != CNT_MAX) begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                    if (core_valid) begin
                        rsp_data <= core_data_out;
                        rsp_err  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_take) begin
                        last_grant <= hold_id;
                    end
                end
                default: ;
            endcase
        end
    end

    // Job holding registers carry no reset; they are only read after a
    // handshake has loaded them.
    always_ff @(posedge clk) begin
        if (state == IDLE && grant_valid) begin
            hold_data <= req_data[int'(grant_idx)*AES_BLOCK_W +: AES_BLOCK_W];
            hold_key  <= req_key[int'(grant_idx)*AES_KEY_W +: AES_KEY_W];
            hold_id   <= grant_idx;
        end
    end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Self-checking bench for aes_core_arbiter with a stand-in AES core.
module tb_aes_core_arbiter;

    localparam int NREQ     = 4;
    localparam int TIMEOUT  = 96;
    localparam int CORE_LAT = 6;

    localparam logic [127:0] FIPS_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] FIPS_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_CT   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] SPUR_DATA = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*128-1:0]   req_data;
    logic [NREQ*256-1:0]   req_key;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [127:0]          rsp_data;
    logic                  rsp_err;
    logic                  core_start;
    logic [127:0]          core_data_in;
    logic [255:0]          core_key;
    logic [127:0]          core_data_out;
    logic                  core_valid;
    logic                  busy;

    logic [127:0] rd [NREQ];
    logic [255:0] rk [NREQ];

    logic         core_valid_m;
    logic [127:0] core_dout_m;
    logic         spurious;
    logic         core_hang;
    logic         start_seen;
    logic [127:0] cap_d;
    logic [255:0] cap_k;
    int           core_left;

    int n_vec;
    int n_fail;
    bit model_en;

    int           m_phase;
    int           m_last;
    int           m_id;
    int           m_el;
    logic [127:0] m_data;
    logic [255:0] m_key;
    logic [127:0] m_rdata;
    logic         m_rerr;

    aes_core_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .req_key       (req_key),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .core_start    (core_start),
        .core_data_in  (core_data_in),
        .core_key      (core_key),
        .core_data_out (core_data_out),
        .core_valid    (core_valid),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        req_data = '0;
        req_key  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*128 +: 128] = rd[i];
            req_key[i*256 +: 256]  = rk[i];
        end
    end

    assign core_valid    = core_valid_m | spurious;
    assign core_data_out = spurious ? SPUR_DATA : core_dout_m;

    // Stand-in for the AES core: the FIPS-197 vector gives its real
    // ciphertext, anything else gets a cheap keyed scramble.
    function automatic logic [127:0] mock(input logic [127:0] d, input logic [255:0] k);
        if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return d ^ k[127:0] ^ k[255:128] ^ 128'h5a5a_0f0f_a5a5_f0f0_1234_5678_9abc_def0;
    endfunction

    function automatic int rrPick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int oneHotIdx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic failWait(input string name);
        n_vec++;
        n_fail++;
        $display("[TB] FAIL %s: awaited event not seen within its cycle budget at %0t", name, $time);
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0] r);
        @(posedge clk);
        #1;
        req_valid = v;
        rsp_ready = r;
    endtask

    // Core model: samples core_start mid-cycle, answers CORE_LAT+1 cycles
    // later with a single core_valid pulse (never when core_hang is set).
    initial begin
        core_valid_m = 1'b0;
        core_dout_m  = '0;
        core_left    = 0;
        start_seen   = 1'b0;
        cap_d        = '0;
        cap_k        = '0;
        forever begin
            @(negedge clk);
            start_seen = rst_n && core_start;
            if (start_seen) begin
                cap_d = core_data_in;
                cap_k = core_key;
            end
            @(posedge clk);
            #1;
            core_valid_m = 1'b0;
            if (!rst_n) begin
                core_left = 0;
            end else if (start_seen) begin
                core_left = core_hang ? 0 : CORE_LAT;
            end else if (core_left > 0) begin
                core_left--;
                if (core_left == 0) begin
                    core_valid_m = 1'b1;
                    core_dout_m  = mock(cap_d, cap_k);
                end
            end
        end
    end

    // Job-level model checked every cycle: a job is accepted, started once,
    // finishes on completion or watchdog, then waits for its own rsp_ready.
    always @(negedge clk) begin
        int g;
        logic [NREQ-1:0] exp_vec;
        g       = -1;
        exp_vec = '0;
        if (!rst_n) begin
            model_en = 1'b1;
            m_phase  = 0;
            m_last   = NREQ - 1;
            m_rdata  = '0;
            m_rerr   = 1'b0;
            checkOutput("rst_req_ready", 256'(req_ready), 256'(0));
            checkOutput("rst_rsp_valid", 256'(rsp_valid), 256'(0));
            checkOutput("rst_core_start", 256'(core_start), 256'(0));
            checkOutput("rst_busy", 256'(busy), 256'(0));
            checkOutput("rst_rsp_data", 256'(rsp_data), 256'(0));
            checkOutput("rst_rsp_err", 256'(rsp_err), 256'(0));
        end else if (model_en) begin
            checkOutput("m_rsp_data", 256'(rsp_data), 256'(m_rdata));
            checkOutput("m_rsp_err", 256'(rsp_err), 256'(m_rerr));
            case (m_phase)
                0: begin
                    g = rrPick(req_valid, m_last);
                    if (g >= 0) exp_vec[g] = 1'b1;
                    checkOutput("m_idle_req_ready", 256'(req_ready), 256'(exp_vec));
                    checkOutput("m_idle_busy", 256'(busy), 256'(0));
                    checkOutput("m_idle_core_start", 256'(core_start), 256'(0));
                    checkOutput("m_idle_rsp_valid", 256'(rsp_valid), 256'(0));
                    if (g >= 0) begin
                        m_id    = g;
                        m_data  = rd[g];
                        m_key   = rk[g];
                        m_phase = 1;
                    end
                end
                1: begin
                    checkOutput("m_start_core_start", 256'(core_start), 256'(1));
                    checkOutput("m_start_busy", 256'(busy), 256'(1));
                    checkOutput("m_start_req_ready", 256'(req_ready), 256'(0));
                    checkOutput("m_start_rsp_valid", 256'(rsp_valid), 256'(0));
                    checkOutput("m_start_core_data_in", 256'(core_data_in), 256'(m_data));
                    checkOutput("m_start_core_key", core_key, m_key);
                    m_el    = 0;
                    m_phase = 2;
                end
                2: begin
                    m_el++;
                    checkOutput("m_busy_core_start", 256'(core_start), 256'(0));
                    checkOutput("m_busy_busy", 256'(busy), 256'(1));
                    checkOutput("m_busy_req_ready", 256'(req_ready), 256'(0));
                    checkOutput("m_busy_rsp_valid", 256'(rsp_valid), 256'(0));
                    checkOutput("m_busy_core_data_in", 256'(core_data_in), 256'(m_data));
                    checkOutput("m_busy_core_key", core_key, m_key);
                    if (core_valid) begin
                        m_rdata = mock(m_data, m_key);
                        m_rerr  = 1'b0;
                        m_phase = 3;
                    end else if (m_el == TIMEOUT - 1) begin
                        m_rdata = '0;
                        m_rerr  = 1'b1;
                        m_phase = 3;
                    end
                end
                default: begin
                    exp_vec[m_id] = 1'b1;
                    checkOutput("m_resp_rsp_valid", 256'(rsp_valid), 256'(exp_vec));
                    checkOutput("m_resp_busy", 256'(busy), 256'(1));
                    checkOutput("m_resp_req_ready", 256'(req_ready), 256'(0));
                    checkOutput("m_resp_core_start", 256'(core_start), 256'(0));
                    if (rsp_ready[m_id]) begin
                        m_last  = m_id;
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    task automatic doReset(input logic [NREQ-1:0] v, input logic [NREQ-1:0] r);
        @(negedge clk);
        #2;
        rst_n     = 1'b0;
        req_valid = v;
        rsp_ready = r;
        #1;
        checkOutput("async_rst_req_ready", 256'(req_ready), 256'(0));
        checkOutput("async_rst_rsp_valid", 256'(rsp_valid), 256'(0));
        checkOutput("async_rst_core_start", 256'(core_start), 256'(0));
        checkOutput("async_rst_busy", 256'(busy), 256'(0));
        checkOutput("async_rst_rsp_data", 256'(rsp_data), 256'(0));
        checkOutput("async_rst_rsp_err", 256'(rsp_err), 256'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic waitReadyThenDrop(input logic [NREQ-1:0] r);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) failWait("wait_req_ready");
        applyStimulus('0, r);
    endtask

    task automatic waitRsp(output int cycles);
        bit ok;
        ok     = 1'b0;
        cycles = 0;
        for (int i = 0; i < TIMEOUT + 50; i++) begin
            @(negedge clk);
            cycles++;
            if (rsp_valid != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) failWait("wait_rsp_valid");
    endtask

    task automatic waitIdle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < TIMEOUT + 50; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) failWait("wait_idle");
    endtask

    initial begin
        int cyc;
        int starts;
        bit ok;
        int exp_order [5];
        int grants [$];
        logic [127:0] held;

        n_vec     = 0;
        n_fail    = 0;
        model_en  = 1'b0;
        rst_n     = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        spurious  = 1'b0;
        core_hang = 1'b0;
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NREQ; i++) begin
            rd[i] = {$urandom, $urandom, $urandom, $urandom};
            rk[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end
        rd[0] = FIPS_PT;
        rk[0] = FIPS_KEY;

        // FIPS-197 AES-256 vector through requester 0
        doReset('0, '0);
        applyStimulus(4'b0001, 4'b0000);
        @(negedge clk);
        checkOutput("fips_first_grant", 256'(req_ready), 256'(4'b0001));
        applyStimulus('0, 4'b0000);
        waitRsp(cyc);
        checkOutput("fips_rsp_valid", 256'(rsp_valid), 256'(4'b0001));
        checkOutput("fips_rsp_data", 256'(rsp_data), 256'(FIPS_CT));
        checkOutput("fips_rsp_err", 256'(rsp_err), 256'(0));
        applyStimulus('0, 4'b0001);
        applyStimulus('0, 4'b1111);
        waitIdle();

        // All requesters valid from reset, rsp_ready high
        rd[0] = {$urandom, $urandom, $urandom, $urandom};
        doReset(4'b1111, 4'b1111);
        starts = 0;
        for (int i = 0; i < 2000 && grants.size() < 5; i++) begin
            @(negedge clk);
            if (core_start) starts++;
            if (req_ready != '0) grants.push_back(oneHotIdx(req_ready));
        end
        if (grants.size() < 5) failWait("wait_five_grants");
        applyStimulus('0, 4'b1111);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (core_start) starts++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) failWait("wait_rr_drain");
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("rr_grant_%0d", i), 256'(i < grants.size() ? grants[i] : -1), 256'(exp_order[i]));
        end
        checkOutput("rr_core_start_count", 256'(starts), 256'(5));

        // Core never answers: watchdog error, then a normal job
        core_hang = 1'b1;
        applyStimulus(4'b0010, 4'b1111);
        waitReadyThenDrop(4'b1111);
        @(negedge clk);
        checkOutput("to_core_start", 256'(core_start), 256'(1));
        waitRsp(cyc);
        checkOutput("to_latency", 256'(cyc), 256'(TIMEOUT));
        checkOutput("to_rsp_valid", 256'(rsp_valid), 256'(4'b0010));
        checkOutput("to_rsp_err", 256'(rsp_err), 256'(1));
        checkOutput("to_rsp_data", 256'(rsp_data), 256'(0));
        core_hang = 1'b0;
        applyStimulus(4'b1000, 4'b1111);
        waitReadyThenDrop(4'b1111);
        waitRsp(cyc);
        checkOutput("after_to_rsp_valid", 256'(rsp_valid), 256'(4'b1000));
        checkOutput("after_to_rsp_err", 256'(rsp_err), 256'(0));
        waitIdle();

        // Response held off 20 cycles; other rsp_ready bits and a stray core_valid
        applyStimulus(4'b0111, 4'b0000);
        waitRsp(cyc);
        held = rsp_data;
        checkOutput("hold_rsp_valid_first", 256'(rsp_valid), 256'(4'b0001));
        applyStimulus(4'b0111, 4'b1110);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            spurious = (i == 10);
            @(negedge clk);
            checkOutput("hold_rsp_valid", 256'(rsp_valid), 256'(4'b0001));
            checkOutput("hold_rsp_data", 256'(rsp_data), 256'(held));
            checkOutput("hold_req_ready", 256'(req_ready), 256'(0));
        end
        @(posedge clk);
        #1;
        spurious = 1'b0;
        applyStimulus('0, 4'b0001);
        applyStimulus('0, 4'b1111);
        @(negedge clk);
        checkOutput("hold_released_busy", 256'(busy), 256'(0));

        // Reset in the middle of a BUSY job
        applyStimulus(4'b0010, 4'b1111);
        waitReadyThenDrop(4'b1111);
        repeat (4) @(negedge clk);
        checkOutput("midbusy_busy", 256'(busy), 256'(1));
        doReset(4'b1001, 4'b1111);
        @(negedge clk);
        checkOutput("post_rst_grant", 256'(req_ready), 256'(4'b0001));
        applyStimulus('0, 4'b1111);
        waitIdle();

        // Wrap-around: serve 3, then only requester 2 asks
        applyStimulus(4'b1000, 4'b1111);
        waitReadyThenDrop(4'b1111);
        waitIdle();
        applyStimulus(4'b0100, 4'b1111);
        @(negedge clk);
        checkOutput("wrap_grant", 256'(req_ready), 256'(4'b0100));
        applyStimulus('0, 4'b1111);
        waitIdle();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
